// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-ported synchronous data memory.
// Port A has fixed priority; port B is forced through after STARVE_LIMIT denied cycles.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_req_i,
  input  logic        a_we_i,
  input  logic [15:0] a_addr_i,
  input  logic [15:0] a_wdata_i,
  output logic        a_gnt_o,
  output logic        a_stall_o,
  output logic        a_rvalid_o,
  output logic [15:0] a_rdata_o,
  input  logic        b_req_i,
  input  logic        b_we_i,
  input  logic [15:0] b_addr_i,
  input  logic [15:0] b_wdata_i,
  output logic        b_gnt_o,
  output logic        b_rvalid_o,
  output logic [15:0] b_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i
);
  typedef enum logic {PRI_A = 1'b0, FORCE_B = 1'b1} state_e;

  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       rd_valid_q, rd_valid_d;
  logic       owner_q, owner_d;  // 0 = read issued by A, 1 = by B
  logic       b_denied;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PRI_A;
    end else begin
      state_q <= state_d;
    end
  end

  // A B grant is impossible to deny in FORCE_B, so only PRI_A can advance the counter.
  always_comb begin
    b_denied   = b_req_i & ~b_gnt_o;
    state_d    = PRI_A;
    wait_cnt_d = 4'd0;
    if (b_denied) begin
      if (wait_cnt_q == LIMIT_M1) begin
        state_d = FORCE_B;
      end else begin
        wait_cnt_d = wait_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    a_gnt_o = 1'b0;
    b_gnt_o = 1'b0;
    case (state_q)
      FORCE_B: begin
        b_gnt_o = b_req_i;
        a_gnt_o = a_req_i & ~b_req_i;
      end
      default: begin
        a_gnt_o = a_req_i;
        b_gnt_o = b_req_i & ~a_req_i;
      end
    endcase
  end

  assign a_stall_o   = a_req_i & ~a_gnt_o;
  assign mem_en_o    = a_gnt_o | b_gnt_o;
  assign mem_we_o    = a_gnt_o ? a_we_i    : (b_gnt_o ? b_we_i    : 1'b0);
  assign mem_addr_o  = a_gnt_o ? a_addr_i  : (b_gnt_o ? b_addr_i  : 16'h0000);
  assign mem_wdata_o = a_gnt_o ? a_wdata_i : (b_gnt_o ? b_wdata_i : 16'h0000);

  assign rd_valid_d = (a_gnt_o & ~a_we_i) | (b_gnt_o & ~b_we_i);
  assign owner_d    = b_gnt_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= 4'd0;
      rd_valid_q <= 1'b0;
      owner_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_valid_q <= rd_valid_d;
      owner_q    <= owner_d;
    end
  end

  assign a_rvalid_o = rd_valid_q & ~owner_q;
  assign b_rvalid_o = rd_valid_q & owner_q;
  assign a_rdata_o  = a_rvalid_o ? mem_rdata_i : 16'h0000;
  assign b_rdata_o  = b_rvalid_o ? mem_rdata_i : 16'h0000;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random traffic,
// compared against a cycle-level reference model with a shadow memory.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [15:0] a_addr = '0, a_wdata = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [15:0] b_addr = '0, b_wdata = '0;
  logic        a_gnt, a_stall, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_stall_o(a_stall), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Synchronous single-port memory behind the arbiter.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  // Reference model: B is forced once it has been refused LIMIT cycles in a row.
  int          waited;
  bit          pend_a, pend_b, eg_a, eg_b;
  logic [15:0] pend_data;
  logic [15:0] shadow [256];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    waited = 0;
    pend_a = 0;
    pend_b = 0;
  endtask

  task automatic settle();
    bit forced;
    #2;
    forced = (waited == LIMIT);
    eg_b   = b_req && (forced || !a_req);
    eg_a   = a_req && !eg_b;
    chk("a_gnt", 16'(a_gnt), 16'(eg_a));
    chk("b_gnt", 16'(b_gnt), 16'(eg_b));
    chk("a_stall", 16'(a_stall), 16'(a_req && !eg_a));
    chk("mem_en", 16'(mem_en), 16'(eg_a || eg_b));
    chk("mem_we", 16'(mem_we), eg_a ? 16'(a_we) : (eg_b ? 16'(b_we) : 16'h0));
    chk("mem_addr", mem_addr, eg_a ? a_addr : (eg_b ? b_addr : 16'h0));
    chk("mem_wdata", mem_wdata, eg_a ? a_wdata : (eg_b ? b_wdata : 16'h0));
    chk("a_rvalid", 16'(a_rvalid), 16'(pend_a));
    chk("b_rvalid", 16'(b_rvalid), 16'(pend_b));
    chk("a_rdata", a_rdata, pend_a ? pend_data : 16'h0);
    chk("b_rdata", b_rdata, pend_b ? pend_data : 16'h0);
    chk("both_rvalid", 16'(a_rvalid & b_rvalid), 16'h0);
    pend_a = eg_a && !a_we;
    pend_b = eg_b && !b_we;
    if (pend_a) pend_data = shadow[a_addr[7:0]];
    if (pend_b) pend_data = shadow[b_addr[7:0]];
    if (eg_a && a_we) shadow[a_addr[7:0]] = a_wdata;
    if (eg_b && b_we) shadow[b_addr[7:0]] = b_wdata;
    waited = (b_req && !eg_b) ? waited + 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic set_a(input logic r, input logic w, input logic [15:0] ad, input logic [15:0] wd);
    a_req = r; a_we = w; a_addr = ad; a_wdata = wd;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [15:0] ad, input logic [15:0] wd);
    b_req = r; b_we = w; b_addr = ad; b_wdata = wd;
  endtask

  bit          pa, pb;
  logic        pa_we, pb_we;
  logic [15:0] pa_addr, pa_wd, pb_addr, pb_wd;

  initial begin
    model_reset();
    // Reset with both masters idle; combinational outputs are valid under reset.
    @(posedge clk);
    #1;
    settle();
    rst = 1'b0;
    tick();
    step();

    // CPU write then read of 0x0010, plus preloads for later scenarios.
    set_a(1, 1, 16'h0010, 16'hBEEF); settle(); chk("t2_mem_we", 16'(mem_we), 16'h1); tick();
    set_a(1, 0, 16'h0010, 16'h0000); step();
    set_a(0, 0, 16'h0000, 16'h0000); settle(); chk("t2_a_rdata", a_rdata, 16'hBEEF); tick();
    set_a(1, 1, 16'h0020, 16'h1234); step();
    set_a(1, 1, 16'h0001, 16'h00AA); step();
    set_a(1, 1, 16'h0002, 16'h00BB); step();
    set_a(0, 0, 16'h0000, 16'h0000); step();

    // Starvation: both request from cycle 0, B forced in cycle 4.
    set_b(1, 0, 16'h0020, 16'h0000);
    for (int c = 0; c < 6; c++) begin
      set_a(1, 0, 16'h0001, 16'h0000);
      settle();
      chk("t3_b_gnt", 16'(b_gnt), 16'(c == 4));
      chk("t3_a_stall", 16'(a_stall), 16'(c == 4));
      tick();
      if (c == 4) set_b(0, 0, 16'h0000, 16'h0000);
    end
    set_a(0, 0, 16'h0000, 16'h0000); step();

    // B alone.
    set_b(1, 0, 16'h0020, 16'h0000); step();
    set_b(0, 0, 16'h0000, 16'h0000); settle(); chk("t4_b_rdata", b_rdata, 16'h1234); tick();

    // Interleaved reads from A then B.
    set_a(1, 0, 16'h0001, 16'h0000); step();
    set_a(0, 0, 16'h0000, 16'h0000); set_b(1, 0, 16'h0002, 16'h0000);
    settle(); chk("t5_a_rdata", a_rdata, 16'h00AA); tick();
    set_b(0, 0, 16'h0000, 16'h0000);
    settle(); chk("t5_b_rdata", b_rdata, 16'h00BB); tick();
    step();

    // Reset arriving while a forced B read is in flight.
    set_a(1, 0, 16'h0001, 16'h0000); set_b(1, 0, 16'h0002, 16'h0000);
    for (int c = 0; c < LIMIT; c++) step();
    settle();
    chk("t6_forced", 16'(b_gnt), 16'h1);
    rst = 1'b1;
    model_reset();
    tick();
    set_a(0, 0, 16'h0000, 16'h0000); set_b(0, 0, 16'h0000, 16'h0000);
    settle();
    chk("t6_b_rvalid", 16'(b_rvalid), 16'h0);
    rst = 1'b0;
    tick();
    set_a(1, 0, 16'h0001, 16'h0000); set_b(1, 0, 16'h0002, 16'h0000);
    settle(); chk("t6_a_wins", 16'(a_gnt), 16'h1); tick();
    set_a(0, 0, 16'h0000, 16'h0000); set_b(0, 0, 16'h0000, 16'h0000);
    step();
    step();

    // Preload the random-traffic window so every read has a known value.
    for (int i = 0; i < 16; i++) begin
      set_a(1, 1, 16'h0040 + 16'(i), 16'($urandom));
      step();
    end
    set_a(0, 0, 16'h0000, 16'h0000);
    step();

    // Random traffic obeying the hold-until-granted protocol.
    pa = 0;
    pb = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pa && $urandom_range(3) != 0) begin
        pa = 1; pa_we = 1'($urandom_range(1));
        pa_addr = 16'h0040 + 16'($urandom_range(15)); pa_wd = 16'($urandom);
      end
      if (!pb && $urandom_range(1) != 0) begin
        pb = 1; pb_we = 1'($urandom_range(1));
        pb_addr = 16'h0040 + 16'($urandom_range(15)); pb_wd = 16'($urandom);
      end
      if (pa) set_a(1, pa_we, pa_addr, pa_wd); else set_a(0, 0, 16'h0000, 16'h0000);
      if (pb) set_b(1, pb_we, pb_addr, pb_wd); else set_b(0, 0, 16'h0000, 16'h0000);
      step();
      if (eg_a) pa = 0;
      if (eg_b) pb = 0;
    end
    set_a(0, 0, 16'h0000, 16'h0000); set_b(0, 0, 16'h0000, 16'h0000);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
